// File: rtl/map_ss_seq.sv
// map_ss_seq -- save-state sequencer for mapper modules.
//
// SAVE walks the mapper's save-state register dump (ss_addr 0..REG_CNT-1,
// then IDX_ADDR for map_idx) and stores each byte in a local buffer.
// LOAD first reads map_idx back and compares it with buffer[REG_CNT]; only
// on a match does it write buffer[0..REG_CNT-1] back to the mapper.
// Every mapper-side strobe is paced by the CPU M2 clock so that mapper
// registers latched on negedge m2 (or on clk while m2 is high) see stable
// address and data.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   m2                  CPU M2 phase, asynchronous to clk
//   cmd_save, cmd_load  one-clk command pulses (SAVE wins if both pulse)
//   hst_addr/_wdat/_we  host byte port into the buffer (writes in IDLE only)
//   hst_rdat            buffer read data, combinational; 0xFF above REG_CNT
//   ss_act              mapper save-state mode
//   ss_we               mapper register write strobe (LOAD data phase)
//   ss_addr, ss_wdat    mapper state index and write data
//   ss_rdat             mapper state readback
//   busy                sequence in progress
//   done                one-clk pulse on successful completion
//   err                 0 ok, 1 map_idx mismatch, 2 m2 timeout; held until
//                       the next command

module map_ss_seq #(
  parameter int REG_CNT  = 6,
  parameter int IDX_ADDR = 127,
  parameter int TMO_CYC  = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m2,
  input  logic       cmd_save,
  input  logic       cmd_load,
  input  logic [7:0] hst_addr,
  input  logic [7:0] hst_wdat,
  input  logic       hst_we,
  output logic [7:0] hst_rdat,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic       busy,
  output logic       done,
  output logic [1:0] err
);

  // Sequence position 0..REG_CNT; the buffer has REG_CNT+1 entries.
  localparam int PW = $clog2(REG_CNT + 1);
  localparam int TW = $clog2(TMO_CYC + 1);

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_IDX = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_W_RISE, S_W_FALL, S_STEP, S_FIN, S_ABORT
  } state_t;

  typedef enum logic {
    MODE_SAVE,
    MODE_LOAD
  } mode_t;

  // Mapper address visited at a given sequence position.
  //   SAVE: 0..REG_CNT-1, then IDX_ADDR.
  //   LOAD: IDX_ADDR (map_idx check), then 0..REG_CNT-1.
  function automatic logic [7:0] pos_addr(input mode_t m, input logic [PW-1:0] p);
    if (m == MODE_SAVE)
      return (p == PW'(REG_CNT)) ? 8'(IDX_ADDR) : 8'(p);
    else
      return (p == '0) ? 8'(IDX_ADDR) : 8'(p - 1'b1);
  endfunction

  // Buffer slot paired with a sequence position; map_idx lives in slot REG_CNT.
  function automatic logic [PW-1:0] pos_bidx(input mode_t m, input logic [PW-1:0] p);
    if (m == MODE_SAVE)
      return p;
    else
      return (p == '0) ? PW'(REG_CNT) : (p - 1'b1);
  endfunction

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t          state_q;
  mode_t           mode_q;
  logic [PW-1:0]   pos_q;
  logic [TW-1:0]   tmo_q;
  logic            ss_act_q;
  logic            ss_we_q;
  logic [7:0]      ss_addr_q;
  logic [7:0]      ss_wdat_q;
  logic            busy_q;
  logic            done_q;
  logic [1:0]      err_q;
  logic [7:0]      mem_q [REG_CNT+1];

  // M2 synchroniser (s1, s2) plus a history flop for edge detection.
  logic            m2_s1_q;
  logic            m2_s2_q;
  logic            m2_prev_q;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic            m2_rise;
  logic            m2_fall;
  logic [PW-1:0]   pos_d;
  logic [PW-1:0]   bidx;
  mode_t           start_mode;
  logic            tmo_hit;
  logic            save_wr;
  logic            host_wr;
  logic            host_in_range;

  assign m2_rise       =  m2_s2_q & ~m2_prev_q;
  assign m2_fall       = ~m2_s2_q &  m2_prev_q;
  assign pos_d         = pos_q + 1'b1;
  assign bidx          = pos_bidx(mode_q, pos_q);
  assign start_mode    = cmd_save ? MODE_SAVE : MODE_LOAD;
  assign tmo_hit       = busy_q && (tmo_q == TW'(TMO_CYC));
  assign host_in_range = (hst_addr <= 8'(REG_CNT));

  // SAVE captures the byte the mapper presents at the end of the bus cycle.
  assign save_wr = (state_q == S_W_FALL) && (mode_q == MODE_SAVE) && m2_fall;
  // The host may only touch the buffer while no sequence owns it.
  assign host_wr = (state_q == S_IDLE) && hst_we && host_in_range;

  always_comb begin
    // NOTE: hst_rdat gets a default before the conditional update so no
    // path leaves it unassigned and no latch is inferred.
    hst_rdat = 8'hFF;
    if (host_in_range) hst_rdat = mem_q[hst_addr[PW-1:0]];
  end

  // ---------------------------------------------------------------------
  // M2 synchroniser and edge history
  // ---------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours (the chain shifts by
  // exactly one stage per clk).
  always_ff @(posedge clk) begin
    if (rst) begin
      m2_s1_q   <= 1'b0;
      m2_s2_q   <= 1'b0;
      m2_prev_q <= 1'b0;
    end else begin
      m2_s1_q   <= m2;
      m2_s2_q   <= m2_s1_q;
      m2_prev_q <= m2_s2_q;
    end
  end

  // ---------------------------------------------------------------------
  // State buffer
  // ---------------------------------------------------------------------
  // NOTE: the buffer has no reset on purpose: a reset mid-sequence must keep
  // whatever was already captured, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (save_wr)
      mem_q[bidx] <= ss_rdat;
    else if (host_wr)
      mem_q[hst_addr[PW-1:0]] <= hst_wdat;
  end

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_SAVE;
      pos_q     <= '0;
      tmo_q     <= '0;
      ss_act_q  <= 1'b0;
      ss_we_q   <= 1'b0;
      ss_addr_q <= 8'h00;
      ss_wdat_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_OK;
    end else begin
      done_q <= 1'b0;

      // Idle-cycle counter: any m2 edge proves the bus is alive.
      if (state_q == S_IDLE || m2_rise || m2_fall)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (cmd_save || cmd_load) begin
            mode_q    <= start_mode;
            pos_q     <= '0;
            ss_addr_q <= pos_addr(start_mode, '0);
            ss_wdat_q <= mem_q[pos_bidx(start_mode, '0)];
            ss_act_q  <= 1'b1;
            busy_q    <= 1'b1;
            err_q     <= ERR_OK;
            state_q   <= S_ARM;
          end
        end

        // Start on a bus-cycle boundary so the first strobe sees a full
        // low phase of stable address.
        S_ARM: begin
          if (m2_fall) state_q <= S_W_RISE;
        end

        S_W_RISE: begin
          if (m2_rise) state_q <= S_W_FALL;
        end

        // ss_we is held through the falling m2 edge and released on the
        // clk that detects it, so the mapper's negedge latch sees it high.
        S_W_FALL: begin
          if (m2_fall) begin
            ss_we_q <= 1'b0;
            if (mode_q == MODE_LOAD && pos_q == '0 &&
                ss_rdat != mem_q[REG_CNT]) begin
              ss_act_q <= 1'b0;
              busy_q   <= 1'b0;
              err_q    <= ERR_IDX;
              state_q  <= S_ABORT;
            end else begin
              state_q  <= S_STEP;
            end
          end
        end

        // Only place where address and data move; ss_we is low here.
        S_STEP: begin
          if (pos_q == PW'(REG_CNT)) begin
            ss_act_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_FIN;
          end else begin
            pos_q     <= pos_d;
            ss_addr_q <= pos_addr(mode_q, pos_d);
            ss_wdat_q <= mem_q[pos_bidx(mode_q, pos_d)];
            // Every LOAD position after the check is a data write.
            ss_we_q   <= (mode_q == MODE_LOAD);
            state_q   <= S_W_RISE;
          end
        end

        S_FIN:   state_q <= S_IDLE;
        S_ABORT: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase

      // A stalled bus overrides whatever the sequence was doing.
      if (tmo_hit) begin
        ss_act_q <= 1'b0;
        ss_we_q  <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
        err_q    <= ERR_TMO;
        state_q  <= S_ABORT;
      end
    end
  end

  assign ss_act  = ss_act_q;
  assign ss_we   = ss_we_q;
  assign ss_addr = ss_addr_q;
  assign ss_wdat = ss_wdat_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_map_ss_seq.sv
// Testbench for map_ss_seq: a mapper model answers the save-state dump,
// a scoreboard queue holds the expected completion (done/err) of every
// command and a monitor pops it whenever busy drops.

module tb_map_ss_seq;

  localparam int REG_CNT  = 6;
  localparam int IDX_ADDR = 127;
  localparam logic [7:0] MAP_IDX = 8'h09;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m2  = 1'b0;
  logic       m2_en = 1'b1;
  logic       cmd_save = 1'b0;
  logic       cmd_load = 1'b0;
  logic [7:0] hst_addr = 8'h00;
  logic [7:0] hst_wdat = 8'h00;
  logic       hst_we = 1'b0;
  logic [7:0] hst_rdat;
  logic       ss_act;
  logic       ss_we;
  logic [7:0] ss_addr;
  logic [7:0] ss_wdat;
  logic [7:0] ss_rdat;
  logic       busy;
  logic       done;
  logic [1:0] err;

  map_ss_seq #(.REG_CNT(REG_CNT), .IDX_ADDR(IDX_ADDR), .TMO_CYC(1023)) dut (
    .clk(clk), .rst(rst), .m2(m2),
    .cmd_save(cmd_save), .cmd_load(cmd_load),
    .hst_addr(hst_addr), .hst_wdat(hst_wdat), .hst_we(hst_we), .hst_rdat(hst_rdat),
    .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdat(ss_wdat),
    .ss_rdat(ss_rdat), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // M2 = clk/12, offset so its edges never coincide with clk edges.
  initial begin
    #3;
    forever begin
      #60;
      m2 = m2_en ? ~m2 : 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Mapper model: registers latch on negedge m2 while ss_act & ss_we.
  // ---------------------------------------------------------------------
  logic [7:0] mreg [REG_CNT] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

  always_comb begin
    ss_rdat = 8'h00;
    if (ss_addr == 8'(IDX_ADDR)) ss_rdat = MAP_IDX;
    else if (ss_addr < 8'(REG_CNT)) ss_rdat = mreg[ss_addr[2:0]];
  end

  always @(negedge m2)
    if (ss_act && ss_we && ss_addr < 8'(REG_CNT)) mreg[ss_addr[2:0]] <= ss_wdat;

  // Event counters, written only here; the stimulus takes differences.
  int act_falls = 0;
  int we_rise_cnt = 0;
  int we_fall_cnt = 0;
  always @(negedge m2) if (ss_act) act_falls++;
  always @(posedge m2) if (ss_we) we_rise_cnt++;
  always @(negedge m2) if (ss_we) we_fall_cnt++;

  // ---------------------------------------------------------------------
  // Scoreboard and checking
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic       done;
    logic [1:0] err;
  } cpl_t;

  cpl_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic busy_prev = 1'b0;
  logic we_prev   = 1'b0;
  logic [7:0] addr_prev = 8'h00;
  logic span_skip = 1'b0;
  int   done_cnt  = 0;
  int   we_pulses = 0;
  int   rise_base = 0;
  int   fall_base = 0;

  always @(negedge clk) begin
    cpl_t e;
    // Completion monitor: pop one expectation each time busy drops.
    if (busy_prev && !busy) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL completion: unexpected, got done=%0b err=%0d, expected none", done, err);
      end else begin
        e = exp_q.pop_front();
        check("completion {done,err}", 32'({done, err}), 32'({e.done, e.err}));
      end
    end
    if (done) done_cnt++;
    // Write-strobe monitor.
    if (ss_we && !we_prev) begin
      we_pulses++;
      rise_base = we_rise_cnt;
      fall_base = we_fall_cnt;
    end
    if (ss_we && we_prev) check("ss_addr stable under ss_we", 32'(ss_addr), 32'(addr_prev));
    if (!ss_we && we_prev && !span_skip)
      check("ss_we spans one m2 rise and fall",
            {16'(we_rise_cnt - rise_base), 16'(we_fall_cnt - fall_base)}, {16'd1, 16'd1});
    busy_prev = busy;
    we_prev   = ss_we;
    addr_prev = ss_addr;
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    hst_addr = a;
    hst_wdat = d;
    hst_we   = 1'b1;
    @(negedge clk);
    hst_we   = 1'b0;
  endtask

  task automatic host_chk(input string name, input logic [7:0] a, input logic [7:0] e);
    @(negedge clk);
    hst_addr = a;
    #1;
    check(name, 32'(hst_rdat), 32'(e));
  endtask

  task automatic pulse_cmd(input logic s, input logic l);
    @(posedge m2);
    @(negedge clk);
    cmd_save = s;
    cmd_load = l;
    @(negedge clk);
    cmd_save = 1'b0;
    cmd_load = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: busy=%0b after %0d clk, expected 0", busy, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_buf(input string name, input logic [7:0] e [REG_CNT+1]);
    for (int i = 0; i <= REG_CNT; i++) host_chk(name, 8'(i), e[i]);
  endtask

  // Safety net against a hung run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    logic [7:0] exp_buf [REG_CNT+1];
    logic [7:0] ld_val  [REG_CNT+1];
    int base;
    int n;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset ss_act", 32'(ss_act), 32'd0);
    check("reset ss_we", 32'(ss_we), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ss_addr", 32'(ss_addr), 32'd0);
    check("reset ss_wdat", 32'(ss_wdat), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;
    host_chk("rdat out of range 7", 8'd7, 8'hFF);
    host_chk("rdat out of range 200", 8'd200, 8'hFF);

    // SAVE: mapper returns 0x10+addr, map_idx 9.
    base = act_falls;
    exp_q.push_back('{done: 1'b1, err: 2'd0});
    pulse_cmd(1'b1, 1'b0);
    wait_idle(400);
    check("save m2 falls with ss_act (arm + 7)", 32'(act_falls - base), 32'd8);
    exp_buf = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h09};
    chk_buf("save buffer", exp_buf);

    // LOAD with matching map_idx; host write during busy is ignored.
    ld_val = '{8'h03, 8'h1F, 8'h02, 8'h04, 8'h05, 8'h01, 8'h09};
    for (int i = 0; i <= REG_CNT; i++) host_wr(8'(i), ld_val[i]);
    host_chk("host write readback", 8'd1, 8'h1F);
    base = we_pulses;
    exp_q.push_back('{done: 1'b1, err: 2'd0});
    pulse_cmd(1'b0, 1'b1);
    repeat (20) @(negedge clk);
    host_wr(8'd0, 8'hEE);
    wait_idle(400);
    check("load ss_we pulse count", 32'(we_pulses - base), 32'd6);
    for (int i = 0; i < REG_CNT; i++) check("load mapper reg", 32'(mreg[i]), 32'(ld_val[i]));
    host_chk("hst_we ignored while busy", 8'd0, 8'h03);

    // LOAD with mismatching map_idx.
    host_wr(8'd6, 8'h0A);
    base = we_pulses;
    exp_q.push_back('{done: 1'b0, err: 2'd1});
    pulse_cmd(1'b0, 1'b1);
    wait_idle(400);
    check("mismatch err", 32'(err), 32'd1);
    check("mismatch busy", 32'(busy), 32'd0);
    check("mismatch ss_act", 32'(ss_act), 32'd0);
    check("mismatch no ss_we", 32'(we_pulses - base), 32'd0);
    check("mismatch mapper reg 1 untouched", 32'(mreg[1]), 32'h1F);

    // m2 held low: timeout.
    m2_en = 1'b0;
    #200;
    exp_q.push_back('{done: 1'b0, err: 2'd2});
    @(negedge clk);
    cmd_save = 1'b1;
    @(negedge clk);
    cmd_save = 1'b0;
    repeat (1000) @(negedge clk);
    check("timeout not yet: busy", 32'(busy), 32'd1);
    check("timeout not yet: err", 32'(err), 32'd0);
    wait_idle(100);
    check("timeout err", 32'(err), 32'd2);
    check("timeout ss_act", 32'(ss_act), 32'd0);
    m2_en = 1'b1;
    #300;

    // SAVE and LOAD together: SAVE runs and picks up the loaded registers.
    exp_q.push_back('{done: 1'b1, err: 2'd0});
    pulse_cmd(1'b1, 1'b1);
    wait_idle(400);
    exp_buf = '{8'h03, 8'h1F, 8'h02, 8'h04, 8'h05, 8'h01, 8'h09};
    chk_buf("save-wins buffer", exp_buf);
    check("save-wins err cleared", 32'(err), 32'd0);

    // Reset during LOAD data phase at index 3.
    ld_val = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h09};
    for (int i = 0; i < REG_CNT; i++) host_wr(8'(i), ld_val[i]);
    exp_q.push_back('{done: 1'b0, err: 2'd0});
    pulse_cmd(1'b0, 1'b1);
    n = 0;
    while (!(ss_we && ss_addr == 8'd3) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("reached load index 3 with ss_we", 32'({ss_we, ss_addr}), 32'({1'b1, 8'd3}));
    span_skip = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst mid-load ss_we", 32'(ss_we), 32'd0);
    check("rst mid-load ss_act", 32'(ss_act), 32'd0);
    check("rst mid-load busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    span_skip = 1'b0;
    check("partial load reg 2", 32'(mreg[2]), 32'h42);
    check("partial load reg 3 untouched", 32'(mreg[3]), 32'h04);
    exp_q.push_back('{done: 1'b1, err: 2'd0});
    pulse_cmd(1'b1, 1'b0);
    wait_idle(400);
    exp_buf = '{8'h40, 8'h41, 8'h42, 8'h04, 8'h05, 8'h01, 8'h09};
    chk_buf("save after reset buffer", exp_buf);

    check("all completions seen", 32'(exp_q.size()), 32'd0);
    check("done pulse count", 32'(done_cnt), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
